store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/my_pkg.sv | 12 +
 rtl/store_buffer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/my_pkg.sv
// Shared types and defaults for the store buffer.
package my_pkg;

  localparam int unsigned SB_DEPTH = 4;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// Circular FIFO of byte-masked stores drained to memory, with store-to-load forwarding.
// A free slot keeps be=0, so the head slot's be doubles as the drain request.
module store_buffer
  import my_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  write,
  input  logic [31:0] write_address,
  input  logic [31:0] DATA_out,
  input  logic        read,
  input  logic [31:0] read_address,
  output logic [31:0] DATA_in,
  output logic [3:0]  mem_write,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_DATA_out,
  input  logic        mem_ready,
  input  logic [31:0] mem_DATA_in,
  output logic        full,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic      w_enq_req;
  logic      w_full;
  logic      w_deq;
  logic      w_enq;
  logic      w_drop;
  sb_entry_t w_incoming;
  logic      w_unused;

  assign w_unused  = ^{write_address[1:0], read_address[1:0]};

  assign w_enq_req = |write;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_deq     = (r_count != '0) && mem_ready;
  // A same-cycle dequeue frees the slot a full-buffer store needs.
  assign w_enq     = w_enq_req && (!w_full || w_deq);
  assign w_drop    = w_enq_req && w_full && !w_deq;

  assign w_incoming = '{waddr: write_address[31:2], be: write, data: DATA_out};

  // Overlay buffered stores oldest to youngest, then the in-flight store.
  function automatic logic [31:0] fwd_merge(
    input logic [31:0]           base,
    input sb_entry_t [DEPTH-1:0] ents,
    input logic [PW-1:0]         head,
    input logic [CW-1:0]         count,
    input logic [29:0]           waddr,
    input sb_entry_t             incoming
  );
    logic [31:0]   d;
    logic [PW-1:0] idx;
    d = base;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (ents[idx].waddr == waddr)) begin
        for (int b = 0; b < 4; b++) begin
          if (ents[idx].be[b]) d[8*b +: 8] = ents[idx].data[8*b +: 8];
        end
      end
    end
    if ((|incoming.be) && (incoming.waddr == waddr)) begin
      for (int b = 0; b < 4; b++) begin
        if (incoming.be[b]) d[8*b +: 8] = incoming.data[8*b +: 8];
      end
    end
    return d;
  endfunction

  always_comb begin
    DATA_in = mem_DATA_in;
    if (read) begin
      DATA_in = fwd_merge(mem_DATA_in, r_mem, r_head, r_count,
                          read_address[31:2], w_incoming);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i].be <= '0;
    end else begin
      if (w_deq) begin
        r_mem[r_head].be <= '0;
        r_head           <= r_head + PW'(1);
      end
      // When full, tail equals head; the new store overrides the clear above.
      if (w_enq) begin
        r_mem[r_tail] <= w_incoming;
        r_tail        <= r_tail + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign mem_write         = r_mem[r_head].be;
  assign mem_write_address = {r_mem[r_head].waddr, 2'b00};
  assign mem_DATA_out      = r_mem[r_head].data;
  assign full              = w_full;
  assign overflow          = r_overflow;

endmodule
